// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
//   Shared definitions for the SoC CPU bus: the address-region enum, the
//   base addresses of every mapped window and the default address widths.
//
//   Optional feature macro: SOC_BUS_RAND_EN
//     defined   -> the RANH/RANV random-number registers are mapped
//     undefined -> those addresses fall into the unmapped region
package soc_bus_pkg;

  localparam int RAM_AW_DEFAULT  = 12;
  localparam int VRAM_AW_DEFAULT = 16;

  // Upper halfword that selects the RAM and VRAM windows
  localparam logic [15:0] RAM_PAGE  = 16'h0000;
  localparam logic [15:0] VRAM_PAGE = 16'h0001;

  // Single-word peripheral registers
  localparam logic [31:0] KEY_ADDR  = 32'hFFFF_0000;
  localparam logic [31:0] MOVE_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] RANH_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] RANV_ADDR = 32'hFFFF_000C;

`ifdef SOC_BUS_RAND_EN
  localparam bit RAND_EN = 1'b1;
`else
  localparam bit RAND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_VRAM,
    REGION_KEY,
    REGION_MOVE,
    REGION_RANH,
    REGION_RANV,
    REGION_NONE
  } region_t;

endpackage

// File: rtl/soc_bus_decode.sv
// soc_bus_decode
//   Purely combinational address decoder: maps a CPU byte address onto the
//   bus region it belongs to.
//
//   Ports
//     cpu_address  in  32  CPU byte address
//     region       out     decoded region (REGION_NONE when unmapped)
//
//   Optional feature macro: SOC_BUS_RAND_EN (maps RANH/RANV when defined)
module soc_bus_decode
  import soc_bus_pkg::*;
(
  input  logic [31:0] cpu_address,
  output region_t     region
);

  // Window decodes take priority over the single-word registers; the two
  // never overlap, so the order only matters for readability.
  always_comb begin
    region = REGION_NONE;
    if (cpu_address[31:16] == RAM_PAGE) begin
      region = REGION_RAM;
    end else if (cpu_address[31:16] == VRAM_PAGE) begin
      region = REGION_VRAM;
    end else if (cpu_address == KEY_ADDR) begin
      region = REGION_KEY;
    end else if (cpu_address == MOVE_ADDR) begin
      region = REGION_MOVE;
    end else if (RAND_EN && (cpu_address == RANH_ADDR)) begin
      region = REGION_RANH;
    end else if (RAND_EN && (cpu_address == RANV_ADDR)) begin
      region = REGION_RANV;
    end
  end

endmodule

// File: rtl/soc_bus.sv
// soc_bus
//   CPU-side bus fabric. Decodes the CPU address, drives the RAM/VRAM write
//   enables, generates one-cycle clear pulses for the keyboard and move timer
//   on writes, and returns read data one cycle after the address (matching
//   the block-RAM read latency).
//
//   Ports
//     mclk          in   1        single clock, rising edge
//     clr           in   1        synchronous active-high reset
//     mem_w         in   1        CPU write strobe
//     cpu_address   in   32       CPU byte address
//     cpu2bus       in   32       CPU write data
//     ram2bus       in   32       RAM read data
//     vram2bus      in   8        VRAM read data
//     key2bus       in   8        keyboard data
//     move2bus      in   1        move-timer flag
//     ran_h, ran_v  in   32       random-number sources
//     ram_w         out  1        RAM write enable (combinational)
//     vram_w        out  1        VRAM write enable (combinational)
//     key_w         out  1        keyboard clear pulse (registered)
//     move_w        out  1        move-timer clear pulse (registered)
//     bus2ram       out  32       RAM write data
//     bus2vram      out  8        VRAM write data
//     ram_address   out  RAM_AW   RAM word address
//     vram_address  out  VRAM_AW  VRAM byte address
//     bus2cpu       out  32       CPU read data
//
//   Optional feature macro: SOC_BUS_RAND_EN (maps ran_h/ran_v when defined)
module soc_bus
  import soc_bus_pkg::*;
#(
  parameter int RAM_AW  = RAM_AW_DEFAULT,
  parameter int VRAM_AW = VRAM_AW_DEFAULT
) (
  input  logic               mclk,
  input  logic               clr,
  input  logic               mem_w,
  input  logic [31:0]        cpu_address,
  input  logic [31:0]        cpu2bus,
  input  logic [31:0]        ram2bus,
  input  logic [7:0]         vram2bus,
  input  logic [7:0]         key2bus,
  input  logic               move2bus,
  input  logic [31:0]        ran_h,
  input  logic [31:0]        ran_v,
  output logic               ram_w,
  output logic               vram_w,
  output logic               key_w,
  output logic               move_w,
  output logic [31:0]        bus2ram,
  output logic [7:0]         bus2vram,
  output logic [RAM_AW-1:0]  ram_address,
  output logic [VRAM_AW-1:0] vram_address,
  output logic [31:0]        bus2cpu
);

  region_t region;
  region_t region_q;

  soc_bus_decode u_decode (
    .cpu_address (cpu_address),
    .region      (region)
  );

  // Addresses and write data pass straight through whatever the region, so
  // the memories see them even during reset.
  assign ram_address  = cpu_address[RAM_AW+1:2];
  assign vram_address = cpu_address[VRAM_AW-1:0];
  assign bus2ram      = cpu2bus;
  assign bus2vram     = cpu2bus[7:0];

  assign ram_w  = mem_w && (region == REGION_RAM);
  assign vram_w = mem_w && (region == REGION_VRAM);

  // Clear pulses follow the write by one edge; a held write keeps them high.
  always_ff @(posedge mclk) begin
    if (clr) begin
      key_w    <= 1'b0;
      move_w   <= 1'b0;
      region_q <= REGION_NONE;
    end else begin
      key_w    <= mem_w && (region == REGION_KEY);
      move_w   <= mem_w && (region == REGION_MOVE);
      region_q <= region;
    end
  end

  // Only the region is registered; peripheral data is taken live in the
  // cycle the registered region selects it.
  always_comb begin
    bus2cpu = 32'h0;
    case (region_q)
      REGION_RAM:  bus2cpu = ram2bus;
      REGION_VRAM: bus2cpu = {24'h0, vram2bus};
      REGION_KEY:  bus2cpu = {24'h0, key2bus};
      REGION_MOVE: bus2cpu = {31'h0, move2bus};
`ifdef SOC_BUS_RAND_EN
      REGION_RANH: bus2cpu = ran_h;
      REGION_RANV: bus2cpu = ran_v;
`endif
      default:     bus2cpu = 32'h0;
    endcase
  end

`ifndef SOC_BUS_RAND_EN
  // The random sources stay on the port list but are deliberately ignored.
  logic unused_rand;
  assign unused_rand = ^{ran_h, ran_v};
`endif

endmodule

// File: tb/tb_soc_bus.sv
// tb_soc_bus
//   Self-checking bench for soc_bus: directed scenarios followed by random
//   traffic, all compared against a behavioural model of the address map.
//   Honours SOC_BUS_RAND_EN the same way the design does.
module tb_soc_bus;

  localparam int RAM_AW  = 12;
  localparam int VRAM_AW = 16;

  // Region codes used only by the reference model
  localparam int R_RAM  = 0;
  localparam int R_VRAM = 1;
  localparam int R_KEY  = 2;
  localparam int R_MOVE = 3;
  localparam int R_RANH = 4;
  localparam int R_RANV = 5;
  localparam int R_NONE = 6;

  logic               mclk = 1'b0;
  logic               clr;
  logic               mem_w;
  logic [31:0]        cpu_address;
  logic [31:0]        cpu2bus;
  logic [31:0]        ram2bus;
  logic [7:0]         vram2bus;
  logic [7:0]         key2bus;
  logic               move2bus;
  logic [31:0]        ran_h;
  logic [31:0]        ran_v;
  logic               ram_w;
  logic               vram_w;
  logic               key_w;
  logic               move_w;
  logic [31:0]        bus2ram;
  logic [7:0]         bus2vram;
  logic [RAM_AW-1:0]  ram_address;
  logic [VRAM_AW-1:0] vram_address;
  logic [31:0]        bus2cpu;

  int errors = 0;
  int checks = 0;

  // Model state: what the bus should present after the last edge
  int exp_region_q;
  bit exp_key;
  bit exp_move;

  soc_bus #(.RAM_AW(RAM_AW), .VRAM_AW(VRAM_AW)) dut (
    .mclk         (mclk),
    .clr          (clr),
    .mem_w        (mem_w),
    .cpu_address  (cpu_address),
    .cpu2bus      (cpu2bus),
    .ram2bus      (ram2bus),
    .vram2bus     (vram2bus),
    .key2bus      (key2bus),
    .move2bus     (move2bus),
    .ran_h        (ran_h),
    .ran_v        (ran_v),
    .ram_w        (ram_w),
    .vram_w       (vram_w),
    .key_w        (key_w),
    .move_w       (move_w),
    .bus2ram      (bus2ram),
    .bus2vram     (bus2vram),
    .ram_address  (ram_address),
    .vram_address (vram_address),
    .bus2cpu      (bus2cpu)
  );

  always #5 mclk = ~mclk;

  function automatic int refRegion(input logic [31:0] a);
    bit rand_en;
`ifdef SOC_BUS_RAND_EN
    rand_en = 1'b1;
`else
    rand_en = 1'b0;
`endif
    if (a[31:16] == 16'h0000) return R_RAM;
    if (a[31:16] == 16'h0001) return R_VRAM;
    if (a == 32'hFFFF_0000) return R_KEY;
    if (a == 32'hFFFF_0004) return R_MOVE;
    if (rand_en && a == 32'hFFFF_0008) return R_RANH;
    if (rand_en && a == 32'hFFFF_000C) return R_RANV;
    return R_NONE;
  endfunction

  function automatic logic [31:0] refRead(input int r);
    case (r)
      R_RAM:   return ram2bus;
      R_VRAM:  return 32'(vram2bus);
      R_KEY:   return 32'(key2bus);
      R_MOVE:  return 32'(move2bus);
      R_RANH:  return ran_h;
      R_RANV:  return ran_v;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
               tag, $time, observed, expected);
    end
  endtask

  // Drives one cycle of CPU inputs, checks every output at the falling edge,
  // then advances the model across the next rising edge.
  task automatic applyStimulus(input logic c, input logic we,
                               input logic [31:0] a, input logic [31:0] d);
    int r;
    clr         = c;
    mem_w       = we;
    cpu_address = a;
    cpu2bus     = d;
    @(negedge mclk);
    r = refRegion(a);
    checkOutput("ram_w",        32'(ram_w),        32'(we && r == R_RAM));
    checkOutput("vram_w",       32'(vram_w),       32'(we && r == R_VRAM));
    checkOutput("ram_address",  32'(ram_address),  (a >> 2) & ((32'd1 << RAM_AW) - 1));
    checkOutput("vram_address", 32'(vram_address), a & ((32'd1 << VRAM_AW) - 1));
    checkOutput("bus2ram",      bus2ram,           d);
    checkOutput("bus2vram",     32'(bus2vram),     d & 32'hFF);
    checkOutput("key_w",        32'(key_w),        32'(exp_key));
    checkOutput("move_w",       32'(move_w),       32'(exp_move));
    checkOutput("bus2cpu",      bus2cpu,           refRead(exp_region_q));
    exp_key      = !c && we && (r == R_KEY);
    exp_move     = !c && we && (r == R_MOVE);
    exp_region_q = c ? R_NONE : r;
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [31:0] randomAddress();
    case ($urandom_range(0, 9))
      0:       return {16'h0000, 16'($urandom)};
      1:       return {16'h0001, 16'($urandom)};
      2:       return 32'hFFFF_0000;
      3:       return 32'hFFFF_0004;
      4:       return 32'hFFFF_0008;
      5:       return 32'hFFFF_000C;
      6:       return 32'hFFFF_0000 + 32'($urandom_range(1, 31));
      7:       return {16'h0002, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clr         = 1'b1;
    mem_w       = 1'b0;
    cpu_address = 32'h0;
    cpu2bus     = 32'h0;
    ram2bus     = 32'hCAFE_F00D;
    vram2bus    = 8'h00;
    key2bus     = 8'h00;
    move2bus    = 1'b0;
    ran_h       = 32'h0;
    ran_v       = 32'h0;
    @(posedge mclk);
    #1;
    exp_region_q = R_NONE;
    exp_key      = 1'b0;
    exp_move     = 1'b0;

    // Reset holds the read path at zero even with a RAM address presented
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'h0);

    // RAM write
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);

    // VRAM read, result one cycle later; then unmapped read and write
    vram2bus = 8'h5A;
    applyStimulus(1'b0, 1'b0, 32'h0001_0123, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0002_0000, 32'h1234_5678);

    // KEY write for one cycle, then KEY read
    applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 32'h0);
    key2bus = 8'h77;
    applyStimulus(1'b0, 1'b0, 32'hFFFF_0000, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);

    // Held KEY write keeps the pulse high
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);

    // MOVE write during reset is dropped; MOVE read after reset
    applyStimulus(1'b1, 1'b1, 32'hFFFF_0004, 32'h0);
    move2bus = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'hFFFF_0004, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);

    // RANH read (mapped or not depending on the build)
    ran_h = 32'h1234_5678;
    applyStimulus(1'b0, 1'b0, 32'hFFFF_0008, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_0008, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ram2bus  = $urandom;
      vram2bus = 8'($urandom);
      key2bus  = 8'($urandom);
      move2bus = 1'($urandom);
      ran_h    = $urandom;
      ran_v    = $urandom;
      applyStimulus(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                    randomAddress(), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
